// File: rtl/fpq_q16_server.sv
// fpq_q16_server: 16-entry circular packet-length source with a deficit round server.
// Optional macro FPQ_PKT_CNT_EN adds pkt_cnt / round_cnt statistics outputs.
`default_nettype none

module fpq_q16_server #(
    parameter logic [1:0] MODE   = 2'b11,
    parameter int         OFFSET = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cur_value,
    input  logic        ena_n,
    output logic        ready,
    output logic        go,
    output logic [7:0]  pkt_len,
    output logic [3:0]  head,
    output logic [8:0]  deficit
`ifdef FPQ_PKT_CNT_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] round_cnt
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READY  = 3'd1;
    localparam logic [2:0] S_ADD    = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_END    = 3'd5;

    localparam logic [3:0] C_OFFSET = OFFSET[3:0];

    logic [2:0] state;
    logic [2:0] next_state;
    logic [7:0] len_table [16];
    logic       can_pop;
    logic [9:0] sum;
    logic [8:0] sum_sat;

    // Constant length table: entry[i] = ((i + OFFSET) mod 16) + 1, lengths 1..16.
    for (genvar i = 0; i < 16; i++) begin : g_table
        localparam logic [3:0] C_IDX = i[3:0] + C_OFFSET;
        assign len_table[i] = {4'b0000, C_IDX} + 8'd1;
    end

    assign pkt_len = len_table[head];
    assign can_pop = ({1'b0, pkt_len} <= deficit);
    assign go      = (state == S_CHECK) && can_pop;
    assign sum     = {1'b0, deficit} + {2'b00, cur_value};
    assign sum_sat = sum[9] ? 9'h1FF : sum[8:0];

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_READY;
            S_READY:  next_state = ena_n ? S_READY : S_ADD;
            S_ADD:    next_state = S_CHECK;
            S_CHECK:  next_state = (can_pop && MODE[1]) ? S_SETTLE : S_END;
            S_SETTLE: next_state = S_CHECK;
            S_END:    next_state = S_READY;
            default:  next_state = S_IDLE;
        endcase
    end

    // ready is a register so it is high exactly while the state is READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ready <= 1'b0;
        end else begin
            state <= next_state;
            ready <= (next_state == S_READY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deficit <= 9'd0;
        end else begin
            case (state)
                S_ADD:   deficit <= sum_sat;
                S_CHECK: if (can_pop) deficit <= deficit - {1'b0, pkt_len};
                S_END:   if (!MODE[0]) deficit <= 9'd0;
                default: deficit <= deficit;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= 4'd0;
        end else if (go) begin
            head <= head + 4'd1;
        end
    end

`ifdef FPQ_PKT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt   <= 16'd0;
            round_cnt <= 16'd0;
        end else begin
            if (go) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (state == S_READY && !ena_n) begin
                round_cnt <= round_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpq_q16_server.sv
// Bench for fpq_q16_server: three instances (MODE 11, 10, 01) checked per round
// against a round-level model of the deficit server.
`default_nettype none

module tb_fpq_q16_server;

    localparam int OFFSET = 3;

    logic       clk;
    logic       rst;
    logic [7:0] cur_v [3];
    logic       ena   [3];
    logic       rdy   [3];
    logic       go_s  [3];
    logic [7:0] plen  [3];
    logic [3:0] hd    [3];
    logic [8:0] def   [3];
`ifdef FPQ_PKT_CNT_EN
    logic [15:0] pcnt [3];
    logic [15:0] rcnt [3];
`endif

    int mode_of [3] = '{3, 2, 1};
    int m_def   [3];
    int m_head  [3];
    int vectors;
    int miscompares;

    typedef struct {
        int k;
        int q;
        int add;
        int pops;
        int fdef;
        int fhead;
    } vec_t;

    vec_t tbl [10];

    fpq_q16_server #(.MODE(2'b11), .OFFSET(OFFSET)) u0 (
        .clk(clk), .rst(rst), .cur_value(cur_v[0]), .ena_n(ena[0]),
        .ready(rdy[0]), .go(go_s[0]), .pkt_len(plen[0]), .head(hd[0]), .deficit(def[0])
`ifdef FPQ_PKT_CNT_EN
        , .pkt_cnt(pcnt[0]), .round_cnt(rcnt[0])
`endif
    );
    fpq_q16_server #(.MODE(2'b10), .OFFSET(OFFSET)) u1 (
        .clk(clk), .rst(rst), .cur_value(cur_v[1]), .ena_n(ena[1]),
        .ready(rdy[1]), .go(go_s[1]), .pkt_len(plen[1]), .head(hd[1]), .deficit(def[1])
`ifdef FPQ_PKT_CNT_EN
        , .pkt_cnt(pcnt[1]), .round_cnt(rcnt[1])
`endif
    );
    fpq_q16_server #(.MODE(2'b01), .OFFSET(OFFSET)) u2 (
        .clk(clk), .rst(rst), .cur_value(cur_v[2]), .ena_n(ena[2]),
        .ready(rdy[2]), .go(go_s[2]), .pkt_len(plen[2]), .head(hd[2]), .deficit(def[2])
`ifdef FPQ_PKT_CNT_EN
        , .pkt_cnt(pcnt[2]), .round_cnt(rcnt[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int len_of(input int h);
        return ((h + OFFSET) % 16) + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Round-level model: add quantum (saturating), pop while covered, optional clear.
    task automatic model_round(input int k, input int q, output int add, output int pops,
                               output int cyc);
        int d;
        int h;
        d = m_def[k] + q;
        if (d > 511) d = 511;
        add  = d;
        h    = m_head[k];
        pops = 0;
        while (d >= len_of(h) && ((mode_of[k] & 2) != 0 || pops == 0)) begin
            d    = d - len_of(h);
            h    = (h + 1) % 16;
            pops = pops + 1;
        end
        if ((mode_of[k] & 1) == 0) d = 0;
        m_def[k]  = d;
        m_head[k] = h;
        cyc = ((mode_of[k] & 2) != 0) ? 2 * pops + 3 : 3;
    endtask

    // Grant one round to instance k and observe it until ready returns.
    task automatic run_round(input int k, input int q, output int add_seen, output int pops,
                             output int cycles);
        int w;
        logic prev;
        int consec;
        w = 0;
        while (!rdy[k] && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!rdy[k]) check("ready_wait_timeout", 0, 1);
        cur_v[k] = q[7:0];
        ena[k]   = 1'b0;
        @(posedge clk); #1;
        ena[k]   = 1'b1;
        check("ready_drop", int'(rdy[k]), 0);
        cycles   = 0;
        pops     = 0;
        prev     = 1'b0;
        consec   = 0;
        add_seen = -1;
        while (!rdy[k] && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) add_seen = int'(def[k]);
            if (go_s[k]) begin
                pops++;
                if (prev) consec = 1;
            end
            prev = go_s[k];
        end
        check("go_back_to_back", consec, 0);
    endtask

    initial begin
        int add_seen;
        int pops;
        int cycles;
        int e_add;
        int e_pops;
        int e_cyc;
        int k;
        int q;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur_v[i] = 8'd0;
            ena[i]   = 1'b1;
        end

        tbl[0] = '{0, 4, 4, 1, 0, 1};
        tbl[1] = '{0, 4, 4, 0, 4, 1};
        tbl[2] = '{0, 4, 8, 1, 3, 2};
        tbl[3] = '{0, 16, 19, 2, 6, 4};
        tbl[4] = '{1, 4, 4, 1, 0, 1};
        tbl[5] = '{1, 4, 4, 0, 0, 1};
        tbl[6] = '{1, 4, 4, 0, 0, 1};
        tbl[7] = '{2, 255, 255, 1, 251, 1};
        tbl[8] = '{2, 255, 506, 1, 501, 2};
        tbl[9] = '{2, 255, 511, 1, 505, 3};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", int'(rdy[i]), 0);
            check("reset_go", int'(go_s[i]), 0);
            check("reset_deficit", int'(def[i]), 0);
            check("reset_head", int'(hd[i]), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", int'(rdy[0]), 1);
        check("idle_pkt_len", int'(plen[0]), 4);
        check("idle_head", int'(hd[0]), 0);
        begin
            int seen_go;
            seen_go = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (go_s[0] || go_s[1] || go_s[2]) seen_go = 1;
            end
            check("idle_no_go", seen_go, 0);
        end

        for (int i = 0; i < 3; i++) begin
            m_def[i]  = 0;
            m_head[i] = 0;
        end
        foreach (tbl[i]) begin
            k = tbl[i].k;
            run_round(k, tbl[i].q, add_seen, pops, cycles);
            check($sformatf("tbl%0d_add", i), add_seen, tbl[i].add);
            check($sformatf("tbl%0d_pops", i), pops, tbl[i].pops);
            check($sformatf("tbl%0d_deficit", i), int'(def[k]), tbl[i].fdef);
            check($sformatf("tbl%0d_head", i), int'(hd[k]), tbl[i].fhead);
            check($sformatf("tbl%0d_pkt_len", i), int'(plen[k]), len_of(tbl[i].fhead));
            m_def[k]  = tbl[i].fdef;
            m_head[k] = tbl[i].fhead;
        end

        // Reset during SETTLE: wait for a pop on u0, move into SETTLE, then reset.
        begin
            int w;
            cur_v[0] = 8'd200;
            ena[0]   = 1'b0;
            @(posedge clk); #1;
            ena[0] = 1'b1;
            w = 0;
            while (!go_s[0] && w < 10) begin
                @(posedge clk); #1;
                w++;
            end
            check("settle_go_seen", int'(go_s[0]), 1);
            @(posedge clk); #2;
            rst = 1'b1;
            #1;
            check("async_rst_ready", int'(rdy[0]), 0);
            check("async_rst_go", int'(go_s[0]), 0);
            check("async_rst_deficit", int'(def[0]), 0);
            check("async_rst_head", int'(hd[0]), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            check("post_rst_head", int'(hd[0]), 0);
            check("post_rst_ready", int'(rdy[0]), 1);
            for (int i = 0; i < 3; i++) begin
                m_def[i]  = 0;
                m_head[i] = 0;
            end
        end

        // Randomised rounds across all three instances.
        for (int r = 0; r < 60; r++) begin
            k = int'($urandom_range(0, 2));
            case ($urandom_range(0, 5))
                0:       q = 0;
                1:       q = 255;
                default: q = int'($urandom_range(1, 40));
            endcase
            model_round(k, q, e_add, e_pops, e_cyc);
            run_round(k, q, add_seen, pops, cycles);
            check("rnd_add", add_seen, e_add);
            check("rnd_pops", pops, e_pops);
            check("rnd_cycles", cycles, e_cyc);
            check("rnd_deficit", int'(def[k]), m_def[k]);
            check("rnd_head", int'(hd[k]), m_head[k]);
            check("rnd_pkt_len", int'(plen[k]), len_of(m_head[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpq_q16_server.md
Name: fpq_q16_server

Overview:
- Self-contained fair-packet-queue test block: a 16-entry circular packet-length source plus a deficit-style round server.
- Each round the server is granted by an active-low enable and adds a quantum (cur_value) to a deficit counter.
- It then pops head packets while the deficit covers the head packet length.
- Used as the packet scheduler slice in FPQ experiments; the upstream controller handshakes via ready/ena_n.

Parameters:
- MODE, 2'b11, bit0=1 carries leftover deficit into the next round (bit0=0 clears it at round end); bit1=1 allows multiple pops per round (bit1=0 at most one pop per round).
- OFFSET, 3, seed of the packet-length table, range 0..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset.
- cur_value  in  8  per-round quantum, sampled in the ADD state.
- ena_n  in  1  active-low round grant, level-sensitive, sampled only in READY.
- ready  out  1  server waiting for a grant.
- go  out  1  one-cycle pop strobe; the head packet is dequeued.
- pkt_len  out  8  length of the current head packet.
- head  out  4  current head index.
- deficit  out  9  deficit counter.

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, ready=0, go=0, deficit=0, head=0.
- Reset mid-operation aborts the round immediately; no pop completes.
- Queue table (constant, 16 entries): entry[i] = ((i+OFFSET) mod 16) + 1, so lengths are 1..16.
- pkt_len = entry[head], a combinational read of registered head.
- Pop: on a cycle with go=1, head <= head+1, wrapping 15 -> 0. pkt_len reflects the new head the following cycle.
- The queue is never empty.
- State machine, one transition per clock:
  - IDLE -> READY unconditionally.
  - READY: ready=1. ena_n=0 -> ADD; else stay.
  - ADD: deficit <= min(deficit + cur_value, 511), saturating. -> CHECK.
  - CHECK: if deficit >= pkt_len, then go=1, deficit <= deficit - pkt_len, and next state = SETTLE if MODE[1]=1, else END. Otherwise -> END.
  - SETTLE: one wait cycle so pkt_len updates; -> CHECK.
  - END: if MODE[0]=0, deficit <= 0. -> READY.
- ready is registered: high exactly while state=READY. It drops in the cycle after ena_n is sampled low.
- go is high only in the CHECK cycle that pops; never on two consecutive cycles.
- cur_value=0: no deficit growth; pops occur only from carried deficit.
- ena_n still low when re-entering READY starts a new round immediately; the grant is level-sensitive.

Optional Feature:
- Macro FPQ_PKT_CNT_EN.
- When defined: adds output pkt_cnt [15:0], reset 0, incremented on every go, wrapping 65535 -> 0. Also adds output round_cnt [15:0], incremented on each ADD entry.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle, ena_n=1, OFFSET=3: after 1 cycle ready=1, pkt_len=4, head=0, go never asserts.
- cur_value=4, MODE=11, ena_n=0 in response to ready: round 1 gives deficit=4 and one go (4), then deficit=0 and pkt_len=5; round 2 gives deficit=4 with no pop; round 3 gives deficit=8, pops 5, deficit=3, then pkt_len=6 and the server waits.
- cur_value=16, MODE=11: a single round pops 6 and 7, leaving deficit 3 + carry; check go spacing of 2 cycles and head increments.
- MODE=10 (no carry), cur_value=4, head len 5: every round ends with deficit=0 and go never asserts.
- Wrap: drive rounds until head reaches 15 (len 3); the next pop gives head=0 and pkt_len=4. Also check saturation: cur_value=255 for 3 rounds with head len above deficit, then deficit=511 max.
- Assert rst during SETTLE: all outputs return to reset values asynchronously, and head=0 after release.
